// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: source side of a 2-phase (toggle) req/ack crossing for WIDTH-bit words.
// Optional ack watchdog (sticky timeout_err) is built only when CDC_TX_TIMEOUT_EN is defined.
module cdc_handshake_tx #(
    parameter int WIDTH          = 32,
    parameter int SYNC_DEPTH     = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [WIDTH-1:0] xfer_data,
    output logic             xfer_req,
    input  logic             xfer_ack,
    output logic             busy,
    output logic             xfer_done,
    output logic             timeout_err,
    input  logic             err_clr
);

    // state    | meaning
    // IDLE     | nothing outstanding; launch allowed once ack_sync matches xfer_req
    // WAIT_ACK | word held on xfer_data, waiting for ack_sync to match xfer_req
    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    localparam int SYNC_STAGES = (SYNC_DEPTH < 2) ? 2 :
                                 ((SYNC_DEPTH > 8) ? 8 : SYNC_DEPTH);

    state_t                 state_q, state_d;
    logic [WIDTH-1:0]       xfer_data_q, xfer_data_d;
    logic                   xfer_req_q, xfer_req_d;
    logic                   xfer_done_q, xfer_done_d;
    logic [SYNC_STAGES-1:0] ack_sync_q, ack_sync_d;
    logic                   ack_sync;
    logic                   ack_match;
    logic                   launch;

    // bit 0 is the first stage sampling the asynchronous ack
    assign ack_sync_d = {ack_sync_q[SYNC_STAGES-2:0], xfer_ack};
    assign ack_sync   = ack_sync_q[SYNC_STAGES-1];
    assign ack_match  = (ack_sync == xfer_req_q);

    assign s_ready   = !reset && (state_q == IDLE) && ack_match;
    assign xfer_data = xfer_data_q;
    assign xfer_req  = xfer_req_q;
    assign busy      = (state_q == WAIT_ACK);
    assign xfer_done = xfer_done_q;

    always_comb begin
        state_d     = state_q;
        xfer_data_d = xfer_data_q;
        xfer_req_d  = xfer_req_q;
        xfer_done_d = 1'b0;
        launch      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (s_valid && s_ready) begin
                    launch      = 1'b1;
                    xfer_data_d = s_data;
                    xfer_req_d  = ~xfer_req_q;
                    state_d     = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (ack_match) begin
                    state_d     = IDLE;
                    xfer_done_d = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            xfer_data_q <= '0;
            xfer_req_q  <= 1'b0;
            xfer_done_q <= 1'b0;
            ack_sync_q  <= '0;
        end else begin
            state_q     <= state_d;
            xfer_data_q <= xfer_data_d;
            xfer_req_q  <= xfer_req_d;
            xfer_done_q <= xfer_done_d;
            ack_sync_q  <= ack_sync_d;
        end
    end

`ifdef CDC_TX_TIMEOUT_EN
    localparam int                CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYCLES - 1);

    // Down-counter loaded on entry/clear; terminal count 0 equals TIMEOUT_CYCLES-1 waited cycles.
    logic [CNT_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             timeout_err_q, timeout_err_d;

    always_comb begin
        tmo_cnt_d     = tmo_cnt_q;
        timeout_err_d = timeout_err_q;
        if (launch) begin
            tmo_cnt_d = CNT_LOAD;
        end else if (state_q == WAIT_ACK) begin
            if (err_clr) begin
                tmo_cnt_d = CNT_LOAD;
            end else if (tmo_cnt_q == '0) begin
                timeout_err_d = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q - 1'b1;
            end
        end
        if (err_clr) begin
            timeout_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tmo_cnt_q     <= CNT_LOAD;
            timeout_err_q <= 1'b0;
        end else begin
            tmo_cnt_q     <= tmo_cnt_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    logic unused_tmo;

    assign unused_tmo  = err_clr | launch | (TIMEOUT_CYCLES == 0);
    assign timeout_err = 1'b0;
`endif

endmodule
